// File: rtl/clk_div_multi.sv
// Multi-channel synchronous clock-enable generator: per-channel programmable divisor,
// periodic or one-shot operation, one-cycle tick strobe and 50% square wave.
module clk_div_multi #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  input  logic [NCH-1:0]   en,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq,
  output logic [NCH-1:0]   done
);

  typedef enum logic [1:0] {
    ModeIdle     = 2'b00,
    ModePeriodic = 2'b01,
    ModeOneShot  = 2'b10
  } mode_e;

  logic [WIDTH-1:0] cnt_q  [NCH];
  logic [WIDTH-1:0] cnt_d  [NCH];
  logic [WIDTH-1:0] div_q  [NCH];
  logic [WIDTH-1:0] div_d  [NCH];
  mode_e            mode_q [NCH];
  mode_e            mode_d [NCH];
  logic [NCH-1:0]   tick_q, tick_d;
  logic [NCH-1:0]   sq_q, sq_d;
  logic [NCH-1:0]   done_q, done_d;

  logic [NCH-1:0]   active, tc, wr_sel, restart;
  mode_e            cfg_mode_eff;

  // Mode 11 is folded into idle so stored modes compare cleanly.
  always_comb begin
    case (cfg_mode)
      2'b01:   cfg_mode_eff = ModePeriodic;
      2'b10:   cfg_mode_eff = ModeOneShot;
      default: cfg_mode_eff = ModeIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]   = cnt_q[i];
      div_d[i]   = div_q[i];
      mode_d[i]  = mode_q[i];
      tick_d[i]  = 1'b0;
      sq_d[i]    = sq_q[i];
      done_d[i]  = done_q[i];

      active[i]  = (mode_q[i] != ModeIdle);
      tc[i]      = active[i] && en[i] && (cnt_q[i] == '0);
      // Out-of-range channel numbers match no channel and are dropped.
      wr_sel[i]  = cfg_we && (cfg_ch == CHW'(i));
      restart[i] = !active[i] || (cfg_mode_eff != mode_q[i]);

      if (wr_sel[i] && restart[i]) begin
        mode_d[i] = cfg_mode_eff;
        div_d[i]  = cfg_div;
        cnt_d[i]  = cfg_div;
        sq_d[i]   = 1'b0;
        done_d[i] = 1'b0;
      end else begin
        if (wr_sel[i]) begin
          // Same-mode write only retargets the divisor; the running count is kept.
          div_d[i]  = cfg_div;
          done_d[i] = 1'b0;
        end
        if (tc[i]) begin
          cnt_d[i]  = wr_sel[i] ? cfg_div : div_q[i];
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
          if (mode_q[i] == ModeOneShot) begin
            done_d[i] = 1'b1;
            mode_d[i] = ModeIdle;
          end
        end else if (active[i] && en[i]) begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= '0;
        mode_q[i] <= ModeIdle;
      end
      tick_q <= '0;
      sq_q   <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        mode_q[i] <= mode_d[i];
      end
      tick_q <= tick_d;
      sq_q   <= sq_d;
      done_q <= done_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign done = done_q;

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, fully synchronous clock-enable generator replacing the ripple flip-flop divider chain. Each of NCH channels has a programmable WIDTH-bit divisor, a periodic or one-shot mode, and a gating enable. Each channel produces a one-cycle `tick` strobe and a 50 % square wave `sq`, and all logic runs on the single system clock. Downstream logic uses `tick` as a clock enable (LED blink, debouncers, UART baud), never as a clock.

## Interface
- NCH, 4: number of independent channels (1..16).
- WIDTH, 16: divisor and counter width.
- CHW, $clog2(NCH) (min 1): width of `cfg_ch`.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset: synchronous, active-high.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  CHW  channel addressed by the write.
- cfg_div  in  WIDTH  divisor D.
- cfg_mode  in  2  channel mode:
  - 00 = idle
  - 01 = periodic
  - 10 = one-shot
  - 11 = treated as 00
- en  in  NCH  per-channel count enable (prescale input); a channel advances only on cycles with en[i]=1.
- tick  out  NCH  registered one-cycle strobe at terminal count.
- sq  out  NCH  registered square wave; toggles on every tick.
- done  out  NCH  sticky one-shot completion flag.

## Operation
- Per-channel state:
  - cnt[WIDTH]: down-counter
  - div[WIDTH]: divisor
  - mode[2]
  - tick, sq, done
- Reset: all cnt, div, mode, tick, sq and done are 0. All outputs are 0 in the cycle after rst is sampled high.
- Terminal count (TC) for channel i: mode≠00 and en[i]=1 and cnt==0.
- Counting per cycle with mode≠00 and en[i]=1:
  - At TC: cnt←div, tick←1, sq←~sq.
  - Otherwise: cnt←cnt−1.
- When en[i]=0 or mode=00: cnt holds and tick←0.
- Period is D+1 enabled cycles. D=0 gives a tick on every enabled cycle. sq period is 2·(D+1) enabled cycles at 50 % duty.
- One-shot (mode 10) at TC:
  - tick←1, done←1, mode←00.
  - sq toggles once, then holds.
- Configuration write (cfg_we=1, cfg_ch<NCH). Modes 11 and 00 are equivalent in all comparisons.
  - Restart case (current mode=00, or cfg_mode≠current mode):
    - mode←cfg_mode, div←cfg_div, cnt←cfg_div, sq←0, done←0.
    - tick is suppressed that cycle, even if TC held.
    - Writing mode 00 stops the channel immediately with sq=0.
  - Update case (cfg_mode==current mode≠00): only div←cfg_div and done←0. cnt is untouched, so the new divisor takes effect at the next reload. This is a glitch-free period change.
  - Update coinciding with TC: tick is emitted, and the reload uses the new cfg_div.
- Writes with cfg_ch≥NCH are ignored.
- Channels are fully independent. A write affects only the addressed channel.
- rst takes priority over cfg_we and over counting. Reset mid-count abandons the count and returns the channel to idle.

## Timing
- tick[i] is high exactly one cycle: the cycle after the edge on which TC was sampled.
- sq[i] changes on the same edge tick[i] rises.
- From a restart write at edge k with D and en held at 1, the first tick is high in cycle k+D+1 and repeats every D+1 cycles.
- done rises together with the one-shot tick and remains high until the next write to that channel or rst.
- Back-to-back cfg_we on consecutive cycles is supported: one write per cycle, no busy state.
- No combinational path from inputs to outputs.

## Test plan
- Reset and idle:
  - Stimulus: rst for 2 cycles, then en=all 1s, no writes for 50 cycles.
  - Required: tick=sq=done=0 throughout.
- Periodic:
  - Stimulus: write ch0 mode 01 D=3, en[0]=1.
  - Required: tick[0] high on cycles k+4, k+8, k+12; sq[0] is 1 for 4 cycles, then 0 for 4 cycles. Also check D=0: tick[0] is continuously high from k+1.
- Enable gating:
  - Stimulus: ch1 D=2, en[1] alternating 1/0.
  - Required: tick[1] is spaced 6 cycles apart; tick is never high in a cycle following en[1]=0.
- Glitch-free update:
  - Stimulus: ch2 running D=9; write mode 01 D=1 mid-period, 5 cycles after a tick.
  - Required: the next tick still arrives 10 cycles after the previous one; subsequent ticks are every 2 cycles. Repeat with the write landing on the TC cycle: tick is emitted, and the following tick comes 2 cycles later.
- One-shot:
  - Stimulus: write ch3 mode 10 D=5, en=1.
  - Required: a single tick[3] at k+6 with done[3]=1 from k+6; no further ticks over 40 cycles. A new write clears done[3].
- Stop, restart and reset mid-operation:
  - Stimulus: write mode 00 to a running channel.
  - Required: sq←0 and tick stays 0.
  - Stimulus: assert rst mid-count on all channels.
  - Required: all outputs are 0 the next cycle, and channels stay idle after rst deasserts. A write to cfg_ch=NCH (when NCH<2^CHW) changes nothing.
